// File: rtl/data_mem_sized.sv
// Byte-addressable 64-bit data memory with RISC-V sized loads/stores and a one-deep response stage.
// Optional macro DATA_MEM_SIZED_MISALIGN_TRAP_EN: fault misaligned accesses instead of aligning them down.
module data_mem_sized #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_size,
    input  logic [AW-1:0] req_addr,
    input  logic [63:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [63:0]   resp_rdata,
    output logic          resp_err
);

    localparam int unsigned LW = $clog2(DEPTH);
    localparam int unsigned HB = LW + 3;

    typedef enum logic {
        S_IDLE,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_rdata;
    logic [63:0] w_rdata_nxt;
    logic        r_err;
    logic        w_err_nxt;
    logic [63:0] r_mem [DEPTH];

    logic [2:0]    w_amask;
    logic [2:0]    w_lane;
    logic [7:0]    w_be;
    logic [7:0]    w_be_sh;
    logic [63:0]   w_bmask;
    logic [63:0]   w_wdata_sh;
    logic [LW-1:0] w_idx;
    logic [63:0]   w_word;
    logic [63:0]   w_shift;
    logic [63:0]   w_load;
    logic          w_hi_bad;
    logic          w_fault;
    logic          w_accept;
    logic          w_complete;
    logic          w_wr;

    // Access geometry: sub-size address mask and byte enables for the access width
    always_comb begin
        w_amask = 3'b000;
        w_be    = 8'h01;
        unique case (req_size[1:0])
            2'd0: begin w_amask = 3'b000; w_be = 8'h01; end
            2'd1: begin w_amask = 3'b001; w_be = 8'h03; end
            2'd2: begin w_amask = 3'b011; w_be = 8'h0F; end
            2'd3: begin w_amask = 3'b111; w_be = 8'hFF; end
            default: ;
        endcase
    end

    assign w_lane     = req_addr[2:0] & ~w_amask;
    assign w_idx      = req_addr[HB-1:3];
    assign w_hi_bad   = (req_addr >> HB) != '0;
    assign w_be_sh    = w_be << w_lane;
    assign w_wdata_sh = req_wdata << {w_lane, 3'b000};

    always_comb begin
        w_bmask = '0;
        for (int i = 0; i < 8; i++) begin
            w_bmask[8*i +: 8] = {8{w_be_sh[i]}};
        end
    end

`ifdef DATA_MEM_SIZED_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = |(req_addr[2:0] & w_amask);
    assign w_fault    = (req_size == 3'b111) | (req_we & req_size[2]) | w_hi_bad | w_misalign;
`else
    assign w_fault    = (req_size == 3'b111) | (req_we & req_size[2]) | w_hi_bad;
`endif

    assign req_ready  = (r_state == S_IDLE) | resp_ready;
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    assign w_accept   = req_valid & req_ready;
    assign w_complete = resp_valid & resp_ready;
    assign w_wr       = w_accept & req_we & ~w_fault;

    // Load path: select lanes, then sign/zero extend by funct3
    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {w_lane, 3'b000};

    always_comb begin
        w_load = '0;
        unique case (req_size)
            3'b000: w_load = {{56{w_shift[7]}},  w_shift[7:0]};
            3'b001: w_load = {{48{w_shift[15]}}, w_shift[15:0]};
            3'b010: w_load = {{32{w_shift[31]}}, w_shift[31:0]};
            3'b011: w_load = w_shift;
            3'b100: w_load = {56'd0, w_shift[7:0]};
            3'b101: w_load = {48'd0, w_shift[15:0]};
            3'b110: w_load = {32'd0, w_shift[31:0]};
            default: w_load = '0;
        endcase
    end

    // Storage array is never reset; writes during reset are suppressed
    always_ff @(posedge clk) begin
        if (!rst && w_wr) begin
            r_mem[w_idx] <= (r_mem[w_idx] & ~w_bmask) | (w_wdata_sh & w_bmask);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // A new acceptance always refills the response stage; a bare completion empties it
    always_comb begin
        w_state_nxt = r_state;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = r_err;
        if (w_accept) begin
            w_state_nxt = S_RESP;
            w_err_nxt   = w_fault;
            w_rdata_nxt = (w_fault || req_we) ? 64'd0 : w_load;
        end else if (w_complete) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b0;
            w_rdata_nxt = 64'd0;
        end
    end

endmodule

// File: tb/tb_data_mem_sized.sv
// Self-checking bench for data_mem_sized: directed vectors plus randomized traffic against a byte-array model.
module tb_data_mem_sized;

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned AW     = 64;
    localparam int unsigned NBYTES = DEPTH * 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [63:0]   req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [63:0]   resp_rdata;
    logic          resp_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mdl [NBYTES];
    logic        m_pend;
    logic [63:0] m_data;
    logic        m_err;

    always #5 clk = ~clk;

    data_mem_sized #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    function automatic int unsigned ref_n(input logic [2:0] sz);
        return 32'd1 << sz[1:0];
    endfunction

    function automatic bit ref_fault(input logic we, input logic [2:0] sz, input logic [63:0] a);
        if (sz == 3'd7) return 1'b1;
        if (we && sz >= 3'd4) return 1'b1;
        if (a >= 64'(NBYTES)) return 1'b1;
`ifdef DATA_MEM_SIZED_MISALIGN_TRAP_EN
        if ((a % 64'(ref_n(sz))) != 64'd0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic int unsigned ref_base(input logic [2:0] sz, input logic [63:0] a);
        return int'(a - (a % 64'(ref_n(sz))));
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] sz, input logic [63:0] a);
        int unsigned n = ref_n(sz);
        int unsigned b = ref_base(sz, a);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < int'(n); i++) v = v | (64'(mdl[b + i]) << (8 * i));
        if (sz < 3'd4 && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] sz, input logic [63:0] a, input logic [63:0] wd);
        int unsigned n = ref_n(sz);
        int unsigned b = ref_base(sz, a);
        for (int i = 0; i < int'(n); i++) mdl[b + i] = wd[8*i +: 8];
    endtask

    task automatic drive(input logic v, input logic we, input logic [2:0] sz,
                         input logic [63:0] a, input logic [63:0] wd, input logic rr);
        req_valid  = v;
        req_we     = we;
        req_size   = sz;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = rr;
    endtask

    // Advance one clock and update the reference model for what that edge did
    task automatic step();
        bit acc;
        bit f;
        @(posedge clk);
        if (rst) begin
            m_pend = 1'b0; m_data = 64'd0; m_err = 1'b0;
        end else begin
            acc = req_valid && (!m_pend || resp_ready);
            if (m_pend && resp_ready) begin
                m_pend = 1'b0; m_data = 64'd0; m_err = 1'b0;
            end
            if (acc) begin
                f      = ref_fault(req_we, req_size, req_addr);
                m_pend = 1'b1;
                m_err  = f;
                m_data = (f || req_we) ? 64'd0 : ref_load(req_size, req_addr);
                if (!f && req_we) ref_store(req_size, req_addr, req_wdata);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        m_pend = 1'b0; m_data = 64'd0; m_err = 1'b0;
        #3;
        n_checks++;
        if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (resp_rdata !== 64'd0) begin n_errors++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
        n_checks++;
        if (resp_err !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%b exp=0", resp_err); end
        n_checks++;
        if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        rst = 1'b0;
    endtask

    // Stores to every word used later; first store lands on the first edge after reset release
    task automatic test_prefill();
        logic [63:0] a;
        for (int w = 0; w < 72; w++) begin
            a = (w < 64) ? 64'(w * 8) : 64'(32'h1000 + (w - 64) * 8);
            drive(1'b1, 1'b1, 3'd3, a, {$urandom, $urandom}, 1'b1);
            step();
            n_checks++;
            if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 64'd0) begin
                n_errors++;
                $display("FAIL prefill_store w=%0d got v=%b e=%b d=%h exp v=1 e=0 d=0", w, resp_valid, resp_err, resp_rdata);
            end
        end
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        step();
        n_checks++;
        if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL prefill_drain got=%b exp=0", resp_valid); end
    endtask

    task automatic test_vectors();
        logic [63:0] old;
        drive(1'b1, 1'b1, 3'd3, 64'h08, 64'h12345678ABCDEF00, 1'b1);
        step();
        drive(1'b1, 1'b0, 3'd3, 64'h08, 64'd0, 1'b1);
        step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 64'h12345678ABCDEF00) begin
            n_errors++;
            $display("FAIL load_d_08 got v=%b e=%b d=%h exp v=1 e=0 d=12345678abcdef00", resp_valid, resp_err, resp_rdata);
        end

        old = ref_load(3'd3, 64'h10);
        drive(1'b1, 1'b1, 3'd0, 64'h11, 64'h80, 1'b1);
        step();
        drive(1'b1, 1'b0, 3'd0, 64'h11, 64'd0, 1'b1);
        step();
        n_checks++;
        if (resp_rdata !== 64'hFFFFFFFFFFFFFF80) begin n_errors++; $display("FAIL load_b_11 got=%h exp=ffffffffffffff80", resp_rdata); end
        drive(1'b1, 1'b0, 3'd4, 64'h11, 64'd0, 1'b1);
        step();
        n_checks++;
        if (resp_rdata !== 64'h80) begin n_errors++; $display("FAIL load_bu_11 got=%h exp=80", resp_rdata); end
        drive(1'b1, 1'b0, 3'd3, 64'h10, 64'd0, 1'b1);
        step();
        n_checks++;
        if (resp_rdata !== ((old & ~64'hFF00) | 64'h8000)) begin
            n_errors++;
            $display("FAIL load_d_10 got=%h exp=%h", resp_rdata, (old & ~64'hFF00) | 64'h8000);
        end

        drive(1'b1, 1'b1, 3'd2, 64'h20, 64'hDEADBEEF, 1'b1);
        step();
        drive(1'b1, 1'b0, 3'd2, 64'h20, 64'd0, 1'b1);
        step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 64'hFFFFFFFFDEADBEEF) begin
            n_errors++;
            $display("FAIL b2b_load_w got v=%b d=%h exp v=1 d=ffffffffdeadbeef", resp_valid, resp_rdata);
        end
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        step();
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 3'd2, 64'h20, 64'd0, 1'b1);
        step();
        drive(1'b1, 1'b0, 3'd1, 64'h22, 64'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (req_ready !== 1'b0) begin n_errors++; $display("FAIL stall_ready c=%0d got=%b exp=0", c, req_ready); end
            step();
            n_checks++;
            if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 64'hFFFFFFFFDEADBEEF) begin
                n_errors++;
                $display("FAIL stall_hold c=%0d got v=%b e=%b d=%h exp v=1 e=0 d=ffffffffdeadbeef", c, resp_valid, resp_err, resp_rdata);
            end
        end
        resp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_errors++; $display("FAIL stall_release_ready got=%b exp=1", req_ready); end
        step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 64'hFFFFFFFFFFFFDEAD) begin
            n_errors++;
            $display("FAIL stall_next_load got v=%b d=%h exp v=1 d=ffffffffffffdead", resp_valid, resp_rdata);
        end
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        step();
        n_checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_zero got v=%b e=%b d=%h exp all 0", resp_valid, resp_err, resp_rdata);
        end
    endtask

    task automatic test_faults();
        logic [63:0] exp_d;
        logic        exp_e;
        drive(1'b1, 1'b1, 3'd3, 64'h1000, 64'h0011223344556677, 1'b1);
        step();
        drive(1'b1, 1'b0, 3'd3, 64'h1004, 64'd0, 1'b1);
        step();
`ifdef DATA_MEM_SIZED_MISALIGN_TRAP_EN
        exp_e = 1'b1; exp_d = 64'd0;
`else
        exp_e = 1'b0; exp_d = 64'h0011223344556677;
`endif
        n_checks++;
        if (resp_err !== exp_e || resp_rdata !== exp_d) begin
            n_errors++;
            $display("FAIL misalign_d got e=%b d=%h exp e=%b d=%h", resp_err, resp_rdata, exp_e, exp_d);
        end
        drive(1'b1, 1'b1, 3'd3, 64'h2000, 64'hFFFF, 1'b1);
        step();
        n_checks++;
        if (resp_err !== 1'b1 || resp_rdata !== 64'd0) begin n_errors++; $display("FAIL range_store got e=%b d=%h exp e=1 d=0", resp_err, resp_rdata); end
        drive(1'b1, 1'b1, 3'd4, 64'h1000, 64'hFF, 1'b1);
        step();
        n_checks++;
        if (resp_err !== 1'b1) begin n_errors++; $display("FAIL store_bu got e=%b exp e=1", resp_err); end
        drive(1'b1, 1'b0, 3'd7, 64'h1000, 64'd0, 1'b1);
        step();
        n_checks++;
        if (resp_err !== 1'b1 || resp_rdata !== 64'd0) begin n_errors++; $display("FAIL size_111 got e=%b d=%h exp e=1 d=0", resp_err, resp_rdata); end
        drive(1'b1, 1'b0, 3'd3, 64'h1000, 64'd0, 1'b1);
        step();
        n_checks++;
        if (resp_err !== 1'b0 || resp_rdata !== 64'h0011223344556677) begin
            n_errors++;
            $display("FAIL fault_no_write got e=%b d=%h exp e=0 d=0011223344556677", resp_err, resp_rdata);
        end
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        step();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 3'd3, 64'h40, 64'hA5A5A5A55A5A5A5A, 1'b1);
        step();
        drive(1'b1, 1'b0, 3'd3, 64'h40, 64'd0, 1'b0);
        step();
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset got v=%b e=%b d=%h exp all 0", resp_valid, resp_err, resp_rdata);
        end
        drive(1'b1, 1'b1, 3'd3, 64'h40, 64'hFFFFFFFFFFFFFFFF, 1'b1);
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        n_checks++;
        if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_drop got=%b exp=0", resp_valid); end
        drive(1'b1, 1'b0, 3'd3, 64'h40, 64'd0, 1'b1);
        step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 64'hA5A5A5A55A5A5A5A) begin
            n_errors++;
            $display("FAIL mem_after_reset got v=%b d=%h exp v=1 d=a5a5a5a55a5a5a5a", resp_valid, resp_rdata);
        end
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        step();
    endtask

    task automatic test_random();
        logic [63:0] a;
        int unsigned mode;
        for (int k = 0; k < 600; k++) begin
            mode = $urandom_range(0, 9);
            if (mode < 8)      a = 64'($urandom_range(0, 511));
            else if (mode < 9) a = 64'(32'h1000 + $urandom_range(0, 63));
            else               a = {$urandom, $urandom};
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                  a, {$urandom, $urandom}, ($urandom_range(0, 9) < 7));
            #1;
            n_checks++;
            if (req_ready !== (!m_pend || resp_ready)) begin
                n_errors++;
                $display("FAIL rand_ready k=%0d got=%b exp=%b", k, req_ready, !m_pend || resp_ready);
            end
            step();
            n_checks++;
            if (resp_valid !== m_pend || resp_err !== m_err || resp_rdata !== m_data) begin
                n_errors++;
                $display("FAIL rand_resp k=%0d got v=%b e=%b d=%h exp v=%b e=%b d=%h",
                         k, resp_valid, resp_err, resp_rdata, m_pend, m_err, m_data);
            end
        end
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        step();
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_vectors();
        test_stall();
        test_faults();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
